multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 0, meaning the memory-wait cycle limit before the ERROR state (0 = wait forever).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port memReady  input  1  memory completes the current request this cycle.
REQ-008 SHALL have port memReq  output  1  memory request active.
REQ-009 SHALL have port memWrite  output  1  the request is a write (valid only with memReq).
REQ-010 SHALL have port iorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 SHALL have port irWrite  output  1  load the instruction register.
REQ-012 SHALL have port pcWrite  output  1  load the PC.
REQ-013 SHALL have port pcSrc  output  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register rs.
REQ-014 SHALL have port aluSrcA  output  1  ALU operand A: 0 = PC, 1 = register A.
REQ-015 SHALL have port aluSrcB  output  2  ALU operand B: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
REQ-016 SHALL have port aluCommand  output  3  ALU command: 0 = add, 1 = sub, 2 = xor, 3 = slt.
REQ-017 SHALL have port regWrite  output  1  register file write enable.
REQ-018 SHALL have port regDst  output  2  write destination: 0 = rt, 1 = rd, 2 = register 31.
REQ-019 SHALL have port memToReg  output  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC.
REQ-020 SHALL have port error  output  1  sticky illegal-instruction or timeout flag.

Function
REQ-021 SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, JAL, JR, ERROR; every output not listed for a state is 0.
REQ-022 SHALL go IDLE->FETCH unconditionally on the first clock edge after reset.
REQ-023 FETCH SHALL assert memReq with iorD=0, aluSrcA=0, aluSrcB=1 and aluCommand=0; in the memReady cycle it asserts irWrite and pcWrite (pcSrc=0) and moves to DECODE, otherwise it holds all outputs and stays.
REQ-024 DECODE SHALL drive aluSrcA=0, aluSrcB=3, aluCommand=0 (branch target to ALUOut), then dispatch: 0x23/0x2B->MEMADR; 0x00 with funct 0x20/0x22/0x2A->EXEC_R; 0x00 with funct 0x08->JR; 0x0E->EXEC_I; 0x05->BRANCH; 0x02->JUMP; 0x03->JAL; anything else->ERROR.
REQ-025 MEMADR SHALL drive aluSrcA=1, aluSrcB=2, aluCommand=0, then go to MEMRD for opcode 0x23 and to MEMWR for 0x2B.
REQ-026 MEMRD/MEMWR SHALL assert memReq and iorD=1 (MEMWR also asserts memWrite), hold until memReady, then go MEMRD->MEMWB and MEMWR->FETCH.
REQ-027 MEMWB SHALL assert regWrite with regDst=0 and memToReg=1, then go to FETCH.
REQ-028 EXEC_R SHALL drive aluSrcA=1 and aluSrcB=0, with aluCommand 0 for funct 0x20, 1 for 0x22 and 3 for 0x2A; EXEC_I SHALL drive aluSrcA=1, aluSrcB=2 and aluCommand=2; both go to ALUWB.
REQ-029 ALUWB SHALL assert regWrite with memToReg=0, using regDst=1 for opcode 0x00 and regDst=0 otherwise, then go to FETCH.
REQ-030 BRANCH SHALL drive aluSrcA=1, aluSrcB=0, aluCommand=1 and pcSrc=1, and assert pcWrite only when zero==0 (bne); it then goes to FETCH.
REQ-031 JUMP SHALL assert pcWrite with pcSrc=2; JR SHALL assert pcWrite with pcSrc=3; JAL SHALL assert regWrite (regDst=2, memToReg=2) and pcWrite (pcSrc=2) in the same cycle. All three then go to FETCH.
REQ-032 ERROR SHALL be terminal until reset, assert error and keep every other output 0.
REQ-033 With MEM_TIMEOUT>0, a wait counter SHALL count consecutive memReq cycles without memReady; reaching MEM_TIMEOUT forces ERROR, and the counter clears on memReady or on leaving a memory state.
REQ-034 A memReady seen outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-035 opcode and funct SHALL be sampled only in DECODE, MEMADR, EXEC_R and ALUWB; the instruction register is stable in those states.

Reset
REQ-036 rst_n low SHALL immediately force state=IDLE, clear the wait counter, clear error and drive all outputs to 0, regardless of any pending memory request.
REQ-037 Reset deassertion SHALL be synchronised to clk by the instantiating level; the block itself SHALL NOT add a synchroniser.

Structure
REQ-038 State encodings, opcode/funct constants and the aluCommand, pcSrc, aluSrcB, regDst and memToReg codes SHALL live in a shared package cpu_pkg that the ALU also uses.
REQ-039 Output decoding SHALL be a single sub-module control_decode (state, opcode, funct, zero, memReady -> outputs); the FSM and counter live in the top.

Verification
REQ-040 Reset then memReady=1 at all times: the sequence is IDLE, FETCH, DECODE, with pcWrite=1 and irWrite=1 in the FETCH cycle.
REQ-041 lw (opcode 0x23) with memReady delayed 3 cycles in MEMRD: memReq is held 4 cycles, then MEMWB gives regWrite=1, regDst=0, memToReg=1; 5 states total excluding stalls.
REQ-042 R-type funct 0x22: EXEC_R gives aluCommand=1, then ALUWB gives regDst=1 and regWrite=1.
REQ-043 bne with zero=1: pcWrite=0 in BRANCH; repeated with zero=0: pcWrite=1 and pcSrc=1.
REQ-044 opcode 0x3F: DECODE->ERROR, error=1 is sticky, and rst_n low clears it asynchronously mid-cycle.
REQ-045 MEM_TIMEOUT=8 with memReady held 0 in FETCH: ERROR is entered after 8 cycles, and no pcWrite is ever asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control FSM states, opcode/funct values and the
// datapath select/command codes seen by the control unit and the ALU.
package cpu_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJump,
    StJal,
    StJr,
    StError
  } state_t;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluXor = 3'd2,
    AluSlt = 3'd3
  } alu_cmd_t;

  typedef enum logic [1:0] {
    PcAlu    = 2'd0,
    PcAluOut = 2'd1,
    PcJump   = 2'd2,
    PcRs     = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    SrcBReg    = 2'd0,
    SrcBFour   = 2'd1,
    SrcBImm    = 2'd2,
    SrcBImmSh2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    DstRt = 2'd0,
    DstRd = 2'd1,
    DstRa = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    WbAluOut = 2'd0,
    WbMdr    = 2'd1,
    WbPc     = 2'd2
  } mem_to_reg_t;

  // States that own an outstanding memory request.
  function automatic logic is_mem_state(state_t s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Output decode for the multicycle control FSM. Everything is a function of
// the current state; memReady qualifies the fetch commit and zero the bne.
module control_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluCommand,
  output logic       regWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       error
);

  // Per-state control word; anything not driven for a state stays 0.
  always_comb begin
    memReq     = 1'b0;
    memWrite   = 1'b0;
    iorD       = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = PcAlu;
    aluSrcA    = 1'b0;
    aluSrcB    = SrcBReg;
    aluCommand = AluAdd;
    regWrite   = 1'b0;
    regDst     = DstRt;
    memToReg   = WbAluOut;
    error      = 1'b0;
    case (state)
      StFetch: begin
        // PC + 4 is computed every fetch cycle but only committed with the IR.
        memReq  = 1'b1;
        aluSrcB = SrcBFour;
        irWrite = memReady;
        pcWrite = memReady;
      end
      StDecode: begin
        aluSrcB = SrcBImmSh2;
      end
      StMemAdr: begin
        aluSrcA = 1'b1;
        aluSrcB = SrcBImm;
      end
      StMemRd: begin
        memReq = 1'b1;
        iorD   = 1'b1;
      end
      StMemWr: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      StMemWb: begin
        regWrite = 1'b1;
        regDst   = DstRt;
        memToReg = WbMdr;
      end
      StExecR: begin
        aluSrcA = 1'b1;
        aluSrcB = SrcBReg;
        case (funct)
          FnSub:   aluCommand = AluSub;
          FnSlt:   aluCommand = AluSlt;
          default: aluCommand = AluAdd;
        endcase
      end
      StExecI: begin
        aluSrcA    = 1'b1;
        aluSrcB    = SrcBImm;
        aluCommand = AluXor;
      end
      StAluWb: begin
        regWrite = 1'b1;
        regDst   = (opcode == OpRType) ? DstRd : DstRt;
        memToReg = WbAluOut;
      end
      StBranch: begin
        // bne: the target was parked in ALUOut during decode.
        aluSrcA    = 1'b1;
        aluSrcB    = SrcBReg;
        aluCommand = AluSub;
        pcSrc      = PcAluOut;
        pcWrite    = ~zero;
      end
      StJump: begin
        pcWrite = 1'b1;
        pcSrc   = PcJump;
      end
      StJr: begin
        pcWrite = 1'b1;
        pcSrc   = PcRs;
      end
      StJal: begin
        pcWrite  = 1'b1;
        pcSrc    = PcJump;
        regWrite = 1'b1;
        regDst   = DstRa;
        memToReg = WbPc;
      end
      StError: begin
        error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: state register, instruction dispatch and an
// optional memory-wait watchdog. Output decoding lives in control_decode.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluCommand,
  output logic       regWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       error
);

  localparam int unsigned CntW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TimeoutLast = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            stalled;
  logic            timeout_hit;

  assign stalled     = is_mem_state(state_q) && !memReady;
  assign timeout_hit = (MEM_TIMEOUT != 0) && stalled && (wait_q == CntW'(TimeoutLast));

  // Wait counter: consecutive stalled request cycles, cleared otherwise.
  always_comb begin
    wait_d = '0;
    if ((MEM_TIMEOUT != 0) && stalled && !timeout_hit) begin
      wait_d = wait_q + CntW'(1);
    end
  end

  // Next-state: dispatch on opcode/funct, watchdog overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (memReady) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType: begin
            case (funct)
              FnAdd, FnSub, FnSlt: state_d = StExecR;
              FnJr:                state_d = StJr;
              default:             state_d = StError;
            endcase
          end
          OpXori:  state_d = StExecI;
          OpBne:   state_d = StBranch;
          OpJ:     state_d = StJump;
          OpJal:   state_d = StJal;
          default: state_d = StError;
        endcase
      end
      StMemAdr: begin
        case (opcode)
          OpLw:    state_d = StMemRd;
          OpSw:    state_d = StMemWr;
          default: state_d = StError;
        endcase
      end
      StMemRd: if (memReady) state_d = StMemWb;
      StMemWr: if (memReady) state_d = StFetch;
      StExecR, StExecI: state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJump, StJal, StJr: state_d = StFetch;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
    if (timeout_hit) state_d = StError;
  end

  // State and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  control_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .memReady   (memReady),
    .memReq     (memReq),
    .memWrite   (memWrite),
    .iorD       (iorD),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluCommand (aluCommand),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .error      (error)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Two instances share stimulus: one
// waits forever on memory, the other has an 8-cycle memory watchdog.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;

  logic       memReq, memWrite, iorD, irWrite, pcWrite, aluSrcA, regWrite, error;
  logic [1:0] pcSrc, aluSrcB, regDst, memToReg;
  logic [2:0] aluCommand;
  logic       t_memReq, t_memWrite, t_iorD, t_irWrite, t_pcWrite, t_aluSrcA, t_regWrite;
  logic       t_error;
  logic [1:0] t_pcSrc, t_aluSrcB, t_regDst, t_memToReg;
  logic [2:0] t_aluCommand;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // {memReq,memWrite,iorD,irWrite,pcWrite,pcSrc,aluSrcA,aluSrcB,aluCommand,
  //  regWrite,regDst,memToReg,error}
  logic [18:0] obs, obs_t;
  assign obs = {memReq, memWrite, iorD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
                aluCommand, regWrite, regDst, memToReg, error};
  assign obs_t = {t_memReq, t_memWrite, t_iorD, t_irWrite, t_pcWrite, t_pcSrc, t_aluSrcA,
                  t_aluSrcB, t_aluCommand, t_regWrite, t_regDst, t_memToReg, t_error};

  localparam logic [18:0] SigIdle      = 19'd0;
  localparam logic [18:0] SigFetchWait = {5'b10000, 2'd0, 1'b0, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigFetchRdy  = {5'b10011, 2'd0, 1'b0, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigDecode    = {5'b00000, 2'd0, 1'b0, 2'd3, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigMemAdr    = {5'b00000, 2'd0, 1'b1, 2'd2, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigMemRd     = {5'b10100, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigMemWr     = {5'b11100, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigMemWb     = {5'b00000, 2'd0, 1'b0, 2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 1'b0};
  localparam logic [18:0] SigExecAdd   = {5'b00000, 2'd0, 1'b1, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigExecSub   = {5'b00000, 2'd0, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigExecSlt   = {5'b00000, 2'd0, 1'b1, 2'd0, 3'd3, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigExecI     = {5'b00000, 2'd0, 1'b1, 2'd2, 3'd2, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigAluWbR    = {5'b00000, 2'd0, 1'b0, 2'd0, 3'd0, 1'b1, 2'd1, 2'd0, 1'b0};
  localparam logic [18:0] SigAluWbI    = {5'b00000, 2'd0, 1'b0, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigBranchNt  = {5'b00000, 2'd1, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigBranchT   = {5'b00001, 2'd1, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigJump      = {5'b00001, 2'd2, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigJr        = {5'b00001, 2'd3, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0};
  localparam logic [18:0] SigJal       = {5'b00001, 2'd2, 1'b0, 2'd0, 3'd0, 1'b1, 2'd2, 2'd2, 1'b0};
  localparam logic [18:0] SigError     = 19'd1;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .memReady   (memReady),
    .memReq     (memReq),
    .memWrite   (memWrite),
    .iorD       (iorD),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluCommand (aluCommand),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .error      (error)
  );

  multicycle_control #(
    .MEM_TIMEOUT (8)
  ) dut_t (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .memReady   (memReady),
    .memReq     (t_memReq),
    .memWrite   (t_memWrite),
    .iorD       (t_iorD),
    .irWrite    (t_irWrite),
    .pcWrite    (t_pcWrite),
    .pcSrc      (t_pcSrc),
    .aluSrcA    (t_aluSrcA),
    .aluSrcB    (t_aluSrcB),
    .aluCommand (t_aluCommand),
    .regWrite   (t_regWrite),
    .regDst     (t_regDst),
    .memToReg   (t_memToReg),
    .error      (t_error)
  );

  // Leaves both DUTs in IDLE at a falling edge with reset released.
  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    memReady = 1'b0;
    zero     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    memReady = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== SigIdle) begin
      errors++;
      $display("FAIL reset outputs: got %h want %h", obs, SigIdle);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [18:0] exp [5] = '{SigIdle, SigFetchRdy, SigDecode, SigJump, SigFetchRdy};
    apply_reset();
    opcode   = 6'h02;
    memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL fetch step %0d: got %h want %h", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    logic [18:0] exp [10] = '{SigIdle, SigFetchRdy, SigDecode, SigMemAdr, SigMemRd, SigMemRd,
                              SigMemRd, SigMemRd, SigMemWb, SigFetchWait};
    logic        mr  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    opcode = 6'h23;
    for (int i = 0; i < 10; i++) begin
      memReady = mr[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL lw step %0d: got %h want %h", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [6] = '{SigIdle, SigFetchRdy, SigDecode, SigMemAdr, SigMemWr, SigFetchWait};
    logic        mr  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    opcode = 6'h2B;
    for (int i = 0; i < 6; i++) begin
      memReady = mr[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL sw step %0d: got %h want %h", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu();
    logic [5:0]  ops [4] = '{6'h00, 6'h00, 6'h00, 6'h0E};
    logic [5:0]  fns [4] = '{6'h20, 6'h22, 6'h2A, 6'h00};
    logic [18:0] ex  [4] = '{SigExecAdd, SigExecSub, SigExecSlt, SigExecI};
    logic [18:0] wb  [4] = '{SigAluWbR, SigAluWbR, SigAluWbR, SigAluWbI};
    logic [18:0] exp [6];
    for (int k = 0; k < 4; k++) begin
      exp = '{SigIdle, SigFetchRdy, SigDecode, ex[k], wb[k], SigFetchWait};
      apply_reset();
      opcode = ops[k];
      funct  = fns[k];
      for (int i = 0; i < 6; i++) begin
        memReady = (i < 2);
        #1;
        checks++;
        if (obs !== exp[i]) begin
          errors++;
          $display("FAIL alu op=%h fn=%h step %0d: got %h want %h", ops[k], fns[k], i, obs,
                   exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    logic [18:0] br [2] = '{SigBranchNt, SigBranchT};
    logic        zv [2] = '{1'b1, 1'b0};
    logic [18:0] exp [5];
    for (int k = 0; k < 2; k++) begin
      exp = '{SigIdle, SigFetchRdy, SigDecode, br[k], SigFetchWait};
      apply_reset();
      opcode = 6'h05;
      zero   = zv[k];
      for (int i = 0; i < 5; i++) begin
        memReady = (i < 2);
        #1;
        checks++;
        if (obs !== exp[i]) begin
          errors++;
          $display("FAIL bne zero=%0b step %0d: got %h want %h", zv[k], i, obs, exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jumps();
    logic [5:0]  ops [2] = '{6'h00, 6'h03};
    logic [5:0]  fns [2] = '{6'h08, 6'h00};
    logic [18:0] js  [2] = '{SigJr, SigJal};
    logic [18:0] exp [5];
    for (int k = 0; k < 2; k++) begin
      exp = '{SigIdle, SigFetchRdy, SigDecode, js[k], SigFetchWait};
      apply_reset();
      opcode = ops[k];
      funct  = fns[k];
      for (int i = 0; i < 5; i++) begin
        memReady = (i < 2);
        #1;
        checks++;
        if (obs !== exp[i]) begin
          errors++;
          $display("FAIL jump op=%h step %0d: got %h want %h", ops[k], i, obs, exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_error();
    logic [18:0] exp [7] = '{SigIdle, SigFetchRdy, SigDecode, SigError, SigError, SigError,
                             SigError};
    apply_reset();
    opcode   = 6'h3F;
    funct    = 6'h00;
    memReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL illegal step %0d: got %h want %h", i, obs, exp[i]);
      end
      @(negedge clk);
    end
    // Reset in the middle of the high phase must clear error without a clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== SigIdle || obs_t !== SigIdle) begin
      errors++;
      $display("FAIL async clear: got %h/%h want %h", obs, obs_t, SigIdle);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    logic [18:0] exp_t;
    logic [18:0] exp;
    apply_reset();
    opcode = 6'h23;
    for (int i = 0; i < 12; i++) begin
      memReady = 1'b0;
      exp_t = (i == 0) ? SigIdle : (i <= 8) ? SigFetchWait : SigError;
      exp   = (i == 0) ? SigIdle : SigFetchWait;
      #1;
      checks++;
      if (obs_t !== exp_t) begin
        errors++;
        $display("FAIL timeout8 step %0d: got %h want %h", i, obs_t, exp_t);
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL no-timeout step %0d: got %h want %h", i, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  // Stalls below the limit in FETCH and in MEMRD must not accumulate.
  task automatic test_timeout_clear();
    logic [18:0] exp [19] = '{SigIdle, SigFetchWait, SigFetchWait, SigFetchWait, SigFetchWait,
                              SigFetchWait, SigFetchRdy, SigDecode, SigMemAdr, SigMemRd,
                              SigMemRd, SigMemRd, SigMemRd, SigMemRd, SigMemRd, SigMemRd,
                              SigMemRd, SigMemWb, SigFetchWait};
    apply_reset();
    opcode = 6'h23;
    for (int i = 0; i < 19; i++) begin
      memReady = (i == 6) || (i == 16);
      #1;
      checks++;
      if (obs_t !== exp[i]) begin
        errors++;
        $display("FAIL timeout clear step %0d: got %h want %h", i, obs_t, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_lw();
    test_sw();
    test_alu();
    test_branch();
    test_jumps();
    test_error();
    test_timeout();
    test_timeout_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
